// File: rtl/histeq_frame_ctrl.sv
// Frame sequencer for histogram equalization: clear RAM, histogram
// pass, CDF/LUT build, mapped write-back pass, sticky interrupt.
module histeq_frame_ctrl #(
  parameter int unsigned HIST_BINS      = 256,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd16777216
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [31:0] i_src_addr,
  input  logic [31:0] i_dst_addr,
  output logic        o_rd_start,
  output logic [31:0] o_rd_addr,
  input  logic        i_rd_done,
  output logic        o_hist_clear,
  output logic        o_lut_en,
  output logic        o_cdf_start,
  input  logic        i_cdf_done,
  output logic        o_wr_start,
  output logic [31:0] o_wr_addr,
  input  logic        i_wr_done,
  output logic        o_busy,
  output logic        o_intr,
  input  logic        i_intr_ack,
  output logic        o_error,
  output logic [2:0]  o_state,
  output logic [15:0] o_frame_cnt
);

  localparam int BW = (HIST_BINS > 1) ? $clog2(HIST_BINS) : 1;
  localparam logic [BW-1:0] BIN_LAST = BW'(HIST_BINS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_PASS1 = 3'd2,
    S_CDF   = 3'd3,
    S_PASS2 = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        start_q;
  logic [BW-1:0] bin_cnt;
  logic [31:0] wdog;
  logic        rd_flag;
  logic        wr_flag;
  logic        p2_rd;
  logic        rd_start;
  logic        cdf_start;
  logic        wr_start;
  logic        intr;
  logic        error;
  logic [15:0] frame_cnt;
  logic [31:0] src_q;
  logic [31:0] dst_q;

  logic start_edge;
  logic wait_st;
  logic wd_hit;
  logic rd_hit;
  logic wr_hit;
  logic done_set;
  logic err_set;

  always_comb begin
    start_edge = i_start & ~start_q;
    wait_st    = (state == S_PASS1) || (state == S_CDF) ||
                 (state == S_PASS2);
    wd_hit     = (TIMEOUT_CYCLES != 32'd0) &&
                 (wdog == TIMEOUT_CYCLES - 32'd1);
    // pass-2 read done only counts once its own start went out
    rd_hit     = rd_flag | (i_rd_done & p2_rd);
    wr_hit     = wr_flag | i_wr_done;
    done_set   = (state == S_DONE) && !i_abort;
    err_set    = (state == S_ERROR) && !i_abort;
    next_state = state;
    unique case (state)
      S_IDLE:  if (start_edge) next_state = S_CLEAR;
      S_CLEAR: if (bin_cnt == BIN_LAST) next_state = S_PASS1;
      S_PASS1: begin
        if (i_rd_done)   next_state = S_CDF;
        else if (wd_hit) next_state = S_ERROR;
      end
      S_CDF: begin
        if (i_cdf_done)  next_state = S_PASS2;
        else if (wd_hit) next_state = S_ERROR;
      end
      S_PASS2: begin
        if (rd_hit && wr_hit) next_state = S_DONE;
        else if (wd_hit)      next_state = S_ERROR;
      end
      S_DONE:  next_state = S_IDLE;
      S_ERROR: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (i_abort) next_state = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      bin_cnt   <= '0;
      wdog      <= '0;
      rd_flag   <= 1'b0;
      wr_flag   <= 1'b0;
      p2_rd     <= 1'b0;
      rd_start  <= 1'b0;
      cdf_start <= 1'b0;
      wr_start  <= 1'b0;
      intr      <= 1'b0;
      error     <= 1'b0;
      frame_cnt <= '0;
      src_q     <= '0;
      dst_q     <= '0;
    end else begin
      state     <= next_state;
      start_q   <= i_start;
      rd_start  <= 1'b0;
      cdf_start <= 1'b0;
      wr_start  <= 1'b0;
      bin_cnt   <= (state == S_CLEAR) ? bin_cnt + 1'b1 : '0;
      if (next_state != state || !wait_st) wdog <= '0;
      else                                 wdog <= wdog + 32'd1;
      if (state == S_IDLE && next_state == S_CLEAR) begin
        src_q <= i_src_addr;
        dst_q <= i_dst_addr;
      end
      if (state != S_PASS1 && next_state == S_PASS1)
        rd_start <= 1'b1;
      if (state != S_CDF && next_state == S_CDF)
        cdf_start <= 1'b1;
      // writer is armed first, reader follows one cycle later
      if (state != S_PASS2 && next_state == S_PASS2)
        wr_start <= 1'b1;
      if (state == S_PASS2 && next_state == S_PASS2 && !p2_rd) begin
        rd_start <= 1'b1;
        p2_rd    <= 1'b1;
      end
      if (next_state != S_PASS2) begin
        p2_rd   <= 1'b0;
        rd_flag <= 1'b0;
        wr_flag <= 1'b0;
      end else if (state == S_PASS2) begin
        if (i_rd_done && p2_rd) rd_flag <= 1'b1;
        if (i_wr_done)          wr_flag <= 1'b1;
      end
      if (done_set) frame_cnt <= frame_cnt + 16'd1;
      if (done_set || err_set) intr <= 1'b1;
      else if (i_intr_ack)     intr <= 1'b0;
      if (err_set)
        error <= 1'b1;
      else if (state == S_IDLE && next_state == S_CLEAR)
        error <= 1'b0;
    end
  end

  assign o_state      = state;
  assign o_busy       = (state != S_IDLE);
  assign o_hist_clear = (state == S_CLEAR);
  assign o_lut_en     = (state == S_PASS2);
  assign o_rd_start   = rd_start;
  assign o_cdf_start  = cdf_start;
  assign o_wr_start   = wr_start;
  assign o_rd_addr    = src_q;
  assign o_wr_addr    = dst_q;
  assign o_intr       = intr;
  assign o_error      = error;
  assign o_frame_cnt  = frame_cnt;

endmodule

// File: tb/tb_histeq_frame_ctrl.sv
// Directed bench for histeq_frame_ctrl: nominal frame, done ordering,
// abort, interrupt ack, counter wrap, reset and watchdog instance.
module tb_histeq_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort_s;
  logic [31:0] src;
  logic [31:0] dst;
  logic        rd_done;
  logic        cdf_done;
  logic        wr_done;
  logic        ack;
  logic        rd_start;
  logic [31:0] rd_addr;
  logic        hist_clear;
  logic        lut_en;
  logic        cdf_start;
  logic        wr_start;
  logic [31:0] wr_addr;
  logic        busy;
  logic        intr;
  logic        error;
  logic [2:0]  state;
  logic [15:0] frame;

  logic        w_start;
  logic        w_rd_done;
  logic        w_rd_start;
  logic [31:0] w_rd_addr;
  logic        w_hist_clear;
  logic        w_lut_en;
  logic        w_cdf_start;
  logic        w_wr_start;
  logic [31:0] w_wr_addr;
  logic        w_busy;
  logic        w_intr;
  logic        w_error;
  logic [2:0]  w_state;
  logic [15:0] w_frame;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  histeq_frame_ctrl #(
    .HIST_BINS(256),
    .TIMEOUT_CYCLES(32'd16777216)
  ) u_dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_start(start), .i_abort(abort_s),
    .i_src_addr(src), .i_dst_addr(dst),
    .o_rd_start(rd_start), .o_rd_addr(rd_addr),
    .i_rd_done(rd_done), .o_hist_clear(hist_clear),
    .o_lut_en(lut_en), .o_cdf_start(cdf_start),
    .i_cdf_done(cdf_done), .o_wr_start(wr_start),
    .o_wr_addr(wr_addr), .i_wr_done(wr_done),
    .o_busy(busy), .o_intr(intr), .i_intr_ack(ack),
    .o_error(error), .o_state(state), .o_frame_cnt(frame)
  );

  histeq_frame_ctrl #(
    .HIST_BINS(4),
    .TIMEOUT_CYCLES(32'd50)
  ) u_wd (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_start(w_start), .i_abort(1'b0),
    .i_src_addr(32'h2000_0000), .i_dst_addr(32'h2100_0000),
    .o_rd_start(w_rd_start), .o_rd_addr(w_rd_addr),
    .i_rd_done(w_rd_done), .o_hist_clear(w_hist_clear),
    .o_lut_en(w_lut_en), .o_cdf_start(w_cdf_start),
    .i_cdf_done(1'b0), .o_wr_start(w_wr_start),
    .o_wr_addr(w_wr_addr), .i_wr_done(1'b0),
    .o_busy(w_busy), .o_intr(w_intr), .i_intr_ack(1'b0),
    .o_error(w_error), .o_state(w_state), .o_frame_cnt(w_frame)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // start a frame and run zero-latency engines up to the first PASS2 cycle
  task automatic to_pass2();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (256) step();
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    cdf_done = 1'b1;
    step();
    cdf_done = 1'b0;
    check("p2_entry", {29'd0, state}, 32'd4);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0; abort_s = 1'b0; ack = 1'b0;
    rd_done = 1'b0; cdf_done = 1'b0; wr_done = 1'b0;
    w_start = 1'b0; w_rd_done = 1'b0;
    src = 32'h1000_0000;
    dst = 32'h1100_0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_intr", {31'd0, intr}, 32'd0);
    check("rst_clear", {31'd0, hist_clear}, 32'd0);
    check("rst_frame", {16'd0, frame}, 32'd0);
    check("rst_rd_addr", rd_addr, 32'd0);
    rst_n = 1'b1;
    step();

    // nominal frame
    start = 1'b1;
    step();
    check("clr_enter", {29'd0, state}, 32'd1);
    n = 0;
    while (hist_clear && n < 1000) begin
      n++;
      step();
    end
    check("clr_len", n, 32'd256);
    check("p1_state", {29'd0, state}, 32'd2);
    check("p1_rd_start", {31'd0, rd_start}, 32'd1);
    check("p1_lut_en", {31'd0, lut_en}, 32'd0);
    check("p1_rd_addr", rd_addr, 32'h1000_0000);
    step();
    check("p1_rd_pulse", {31'd0, rd_start}, 32'd0);
    repeat (99) step();
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    check("cdf_state", {29'd0, state}, 32'd3);
    check("cdf_start", {31'd0, cdf_start}, 32'd1);
    repeat (10) step();
    cdf_done = 1'b1;
    step();
    cdf_done = 1'b0;
    check("p2_state", {29'd0, state}, 32'd4);
    check("p2_wr_start", {31'd0, wr_start}, 32'd1);
    check("p2_rd_early", {31'd0, rd_start}, 32'd0);
    check("p2_lut_en", {31'd0, lut_en}, 32'd1);
    check("p2_wr_addr", wr_addr, 32'h1100_0000);
    step();
    check("p2_rd_start", {31'd0, rd_start}, 32'd1);
    check("p2_wr_pulse", {31'd0, wr_start}, 32'd0);
    repeat (100) step();
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    check("p2_wait_wr", {29'd0, state}, 32'd4);
    repeat (4) step();
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    check("done_state", {29'd0, state}, 32'd5);
    step();
    check("nom_intr", {31'd0, intr}, 32'd1);
    check("nom_frame", {16'd0, frame}, 32'd1);
    check("nom_error", {31'd0, error}, 32'd0);
    check("nom_busy", {31'd0, busy}, 32'd0);
    repeat (3) step();
    check("start_held", {29'd0, state}, 32'd0);
    start = 1'b0;
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("ack_clr", {31'd0, intr}, 32'd0);

    // wr_done first; rd_done before its own start is ignored
    to_pass2();
    wr_done = 1'b1;
    rd_done = 1'b1;
    step();
    wr_done = 1'b0;
    rd_done = 1'b0;
    step();
    check("early_rd_ign", {29'd0, state}, 32'd4);
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    check("wr_first", {29'd0, state}, 32'd5);
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;

    // both done in the same cycle, with ack colliding with DONE
    to_pass2();
    step();
    rd_done = 1'b1;
    wr_done = 1'b1;
    step();
    rd_done = 1'b0;
    wr_done = 1'b0;
    check("both_same", {29'd0, state}, 32'd5);
    ack = 1'b1;
    step();
    check("ack_collide", {31'd0, intr}, 32'd1);
    step();
    ack = 1'b0;
    check("ack_later", {31'd0, intr}, 32'd0);

    // rd_done before wr_done
    to_pass2();
    step();
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    check("rd_first_wait", {29'd0, state}, 32'd4);
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    check("rd_first", {29'd0, state}, 32'd5);
    step();
    check("order_frame", {16'd0, frame}, 32'd4);
    ack = 1'b1;
    step();
    ack = 1'b0;

    // start edge inside PASS1 is dropped
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (256) step();
    check("p1_reach", {29'd0, state}, 32'd2);
    start = 1'b1;
    step();
    check("p1_start_ign", {29'd0, state}, 32'd2);
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    cdf_done = 1'b1;
    step();
    cdf_done = 1'b0;
    step();
    rd_done = 1'b1;
    wr_done = 1'b1;
    step();
    rd_done = 1'b0;
    wr_done = 1'b0;
    step();
    repeat (2) step();
    check("no_queued", {29'd0, state}, 32'd0);
    check("p1_frame", {16'd0, frame}, 32'd5);
    start = 1'b0;
    ack = 1'b1;
    step();
    ack = 1'b0;

    // abort in PASS2 together with a start edge
    to_pass2();
    step();
    start = 1'b1;
    abort_s = 1'b1;
    step();
    abort_s = 1'b0;
    check("abort_state", {29'd0, state}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (2) step();
    check("abort_norst", {29'd0, state}, 32'd0);
    check("abort_intr", {31'd0, intr}, 32'd0);
    check("abort_frame", {16'd0, frame}, 32'd5);
    start = 1'b0;
    step();

    // frame counter wrap
    force u_dut.frame_cnt = 16'hFFFF;
    step();
    release u_dut.frame_cnt;
    step();
    check("wrap_pre", {16'd0, frame}, 32'h0000_FFFF);
    to_pass2();
    step();
    rd_done = 1'b1;
    wr_done = 1'b1;
    step();
    rd_done = 1'b0;
    wr_done = 1'b0;
    step();
    check("wrap_frame", {16'd0, frame}, 32'd0);
    check("wrap_intr", {31'd0, intr}, 32'd1);

    // asynchronous reset in the middle of CLEAR
    src = 32'h3000_0000;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    check("mid_clear", {31'd0, hist_clear}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", {29'd0, state}, 32'd0);
    check("arst_clear", {31'd0, hist_clear}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_intr", {31'd0, intr}, 32'd0);
    check("arst_rd_addr", rd_addr, 32'd0);
    check("arst_wr_addr", wr_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // watchdog: CDF never completes
    w_start = 1'b1;
    step();
    w_start = 1'b0;
    repeat (4) step();
    check("wd_p1", {29'd0, w_state}, 32'd2);
    w_rd_done = 1'b1;
    step();
    w_rd_done = 1'b0;
    check("wd_cdf", {29'd0, w_state}, 32'd3);
    repeat (49) step();
    check("wd_before", {29'd0, w_state}, 32'd3);
    step();
    check("wd_err", {29'd0, w_state}, 32'd6);
    step();
    check("wd_idle", {29'd0, w_state}, 32'd0);
    check("wd_error", {31'd0, w_error}, 32'd1);
    check("wd_intr", {31'd0, w_intr}, 32'd1);
    check("wd_frame", {16'd0, w_frame}, 32'd0);
    w_start = 1'b1;
    step();
    w_start = 1'b0;
    check("wd_restart", {29'd0, w_state}, 32'd1);
    check("wd_err_clr", {31'd0, w_error}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
